usig_mult: RTL and testbench
============================

Name: usig_mult

Overview:
- Unsigned integer multiplier: two WIDTH-bit operands in, full 2*WIDTH-bit product out.
- Product is available combinationally (oY) and as a registered copy (oYReg) for downstream synchronous logic.
- Combinational path is built as an explicit array multiplier of partial-product AND terms reduced by full-adder rows. A `*` operator is not used, so the result is portable and gate-count predictable.
- Sits in the arithmetic test datapath as the unsigned counterpart of the signed multiplier block.

Parameters:
- WIDTH, 4, operand width in bits; product width is 2*WIDTH.

Ports:
- iClk  input  1  clock, rising-edge active.
- iRst  input  1  asynchronous reset, active-high.
- iX1  input  WIDTH  multiplicand, unsigned.
- iX2  input  WIDTH  multiplier, unsigned.
- oY  output  2*WIDTH  combinational product iX1*iX2, unsigned.
- oYReg  output  2*WIDTH  oY registered on rising iClk.
- oHi  output  1  combinational; 1 when oY[2*WIDTH-1:WIDTH] is nonzero, i.e. product exceeds WIDTH bits.

Behaviour:
- Arithmetic:
  - Operands are zero-extended, never sign-extended.
  - oY equals the exact mathematical product; it cannot overflow 2*WIDTH bits (max (2^W-1)^2 < 2^(2W)).
- Combinational path (oY, oHi):
  - Purely combinational; no dependence on iClk or iRst.
  - oY settles within the same delta/timestep as any operand change.
  - Must be valid when sampled half a clock period after operands change on a rising edge.
- Structure:
  - Partial products pp[i][j] = iX1[j] & iX2[i].
  - Rows reduced by a generate-built ripple/carry-save array of full and half adders.
  - Final carry-propagate row forms the upper bits.
- Registered path (oYReg):
  - On iRst=1, oYReg = 0 immediately, regardless of iClk.
  - While iRst=1, oYReg holds 0.
  - On each rising iClk with iRst=0, oYReg <= oY. Latency is exactly 1 cycle from the operands present before the edge.
  - Operands changing in the same timestep as the rising edge are not captured until the next edge; oYReg uses the pre-edge value.
- Reset mid-operation: oYReg clears asynchronously; oY and oHi keep tracking operands unaffected.
- Deassertion: the first rising edge after iRst falls loads the current product.
- No X propagation from reset: oYReg is defined 0 before the first clock edge whenever iRst is asserted at time 0.
- Reset values: oYReg = 0. oY and oHi have no reset value; they are a function of the operands only, so oY = 0 and oHi = 0 when both operands are 0.
- WIDTH must be >= 2; smaller values are unsupported.

Test Plan:
- Exhaustive sweep, WIDTH=4: iX1 and iX2 each over 0..F (256 pairs, iX2 changed on rising edge, sampled on falling edge) -> oY == iX1*iX2 for all pairs.
- Corner values: 0*F -> oY=00, oHi=0; 1*F -> 0F, oHi=0; F*F -> E1, oHi=1; 4*4 -> 10, oHi=1; 3*5 -> 0F, oHi=0.
- Registered latency: apply 7*9 then A*B on consecutive cycles -> oYReg shows 3F one edge after the first, then 6E one edge after the second.
- Async reset: oYReg=6E, assert iRst between clock edges -> oYReg=00 immediately; oY still 6E. Deassert; next rising edge -> oYReg=6E.
- Parameter check, WIDTH=8: FF*FF -> oY=FE01, oHi=1; 80*02 -> 0100, oHi=1; random 1000 pairs checked against a reference model.

Source files
------------

// File: rtl/usig_mult.sv
// usig_mult: unsigned WIDTH x WIDTH array multiplier.
// oY and oHi are combinational. oYReg is a registered copy of oY
// with an asynchronous active-high clear.
// The product is built from partial-product AND terms.
// Each partial-product row is added into the shifted running sum by a
// ripple row of full adders; the last row forms the upper product bits.
module usig_mult #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic [WIDTH-1:0]   iX1,
  input  logic [WIDTH-1:0]   iX2,
  output logic [2*WIDTH-1:0] oY,
  output logic [2*WIDTH-1:0] oYReg,
  output logic               oHi
);

  logic [2*WIDTH-1:0] y_d;
  logic [2*WIDTH-1:0] y_q;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_row
      logic [WIDTH-1:0]   pp;    // pp[j] = iX1[j] & iX2[gi]
      logic [WIDTH:0]     acc;   // running sum after adding this row, carry-out on top
      logic [2*WIDTH-1:0] part;  // product bits already retired below this row

      // Partial-product row for multiplier bit gi
      always_comb begin
        pp = iX1 & {WIDTH{iX2[gi]}};
      end

      if (gi == 0) begin : g_first
        // First row needs no adders: it seeds the running sum directly
        always_comb begin
          acc  = {1'b0, pp};
          part = '0;
        end
      end else begin : g_add
        logic [WIDTH:0] prev;
        logic           carry;

        // The running sum shifts right one place per row.
        // Its LSB retires as product bit gi-1.
        // The remaining bits ripple-add with this row's partial products.
        always_comb begin
          prev  = g_row[gi-1].acc;
          carry = 1'b0;
          acc   = '0;
          for (int unsigned j = 0; j < WIDTH; j++) begin
            acc[j] = prev[j+1] ^ pp[j] ^ carry;
            carry  = (prev[j+1] & pp[j]) | (carry & (prev[j+1] ^ pp[j]));
          end
          acc[WIDTH] = carry;
          part       = g_row[gi-1].part;
          part[gi-1] = prev[0];
        end
      end
    end
  endgenerate

  // Assemble the product: retired low bits, then the final row on top
  always_comb begin
    y_d                    = g_row[WIDTH-1].part;
    y_d[2*WIDTH-1:WIDTH-1] = g_row[WIDTH-1].acc;
  end

  // Registered product copy, cleared asynchronously by reset
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  // Drive outputs; oHi flags a product that does not fit in WIDTH bits
  always_comb begin
    oY    = y_d;
    oYReg = y_q;
    oHi   = |y_d[2*WIDTH-1:WIDTH];
  end

endmodule

// File: tb/tb_usig_mult.sv
// tb_usig_mult: checks a WIDTH=4 and a WIDTH=8 usig_mult instance.
// Expected values come from plain integer multiplication.
module tb_usig_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  x1_a, x2_a;
  logic [7:0]  y_a, yreg_a;
  logic        hi_a;
  logic [7:0]  x1_b, x2_b;
  logic [15:0] y_b, yreg_b;
  logic        hi_b;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  usig_mult #(.WIDTH(4)) u_dut4 (
    .iClk (clk),
    .iRst (rst),
    .iX1  (x1_a),
    .iX2  (x2_a),
    .oY   (y_a),
    .oYReg(yreg_a),
    .oHi  (hi_a)
  );

  usig_mult #(.WIDTH(8)) u_dut8 (
    .iClk (clk),
    .iRst (rst),
    .iX1  (x1_b),
    .iX2  (x2_b),
    .oY   (y_b),
    .oYReg(yreg_b),
    .oHi  (hi_b)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned ref_mul(input int unsigned a, input int unsigned b);
    return a * b;
  endfunction

  function automatic logic ref_hi(input int unsigned a, input int unsigned b, input int unsigned w);
    return (a * b) >= (32'd1 << w);
  endfunction

  int unsigned prev_a, prev_b, ra, rb;
  logic [3:0] ca [5] = '{4'h0, 4'h1, 4'hF, 4'h4, 4'h3};
  logic [3:0] cb [5] = '{4'hF, 4'hF, 4'hF, 4'h4, 4'h5};
  logic [7:0] da [2] = '{8'hFF, 8'h80};
  logic [7:0] db [2] = '{8'hFF, 8'h02};

  initial begin
    rst  = 1'b1;
    x1_a = '0; x2_a = '0;
    x1_b = '0; x2_b = '0;
    #1;
    check("rst_yreg4", {8'h00, yreg_a}, 16'h0000);
    check("rst_yreg8", yreg_b, 16'h0000);
    check("zero_y4", {8'h00, y_a}, 16'h0000);
    check("zero_hi4", {15'd0, hi_a}, 16'h0000);
    @(posedge clk); #1;
    check("rst_hold4", {8'h00, yreg_a}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Exhaustive 4-bit sweep with random 8-bit operands alongside
    prev_a = 0; prev_b = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        @(posedge clk); #1;
        check("pipe4", {8'h00, yreg_a}, 16'(prev_a));
        check("pipe8", yreg_b, 16'(prev_b));
        x1_a = 4'(a); x2_a = 4'(b);
        x1_b = 8'($urandom_range(255)); x2_b = 8'($urandom_range(255));
        @(negedge clk);
        check("sweep_y4", {8'h00, y_a}, 16'(ref_mul(a, b)));
        check("sweep_hi4", {15'd0, hi_a}, {15'd0, ref_hi(a, b, 4)});
        check("rand_y8", y_b, 16'(ref_mul(x1_b, x2_b)));
        prev_a = ref_mul(a, b);
        prev_b = ref_mul(x1_b, x2_b);
      end
    end

    // 1000 random 8-bit pairs
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      check("pipe8r", yreg_b, 16'(prev_b));
      ra = $urandom_range(255); rb = $urandom_range(255);
      x1_b = 8'(ra); x2_b = 8'(rb);
      @(negedge clk);
      check("rand_y8", y_b, 16'(ref_mul(ra, rb)));
      check("rand_hi8", {15'd0, hi_b}, {15'd0, ref_hi(ra, rb, 8)});
      prev_b = ref_mul(ra, rb);
    end

    // 4-bit corner values
    for (int k = 0; k < 5; k++) begin
      x1_a = ca[k]; x2_a = cb[k];
      #1;
      check("corner_y4", {8'h00, y_a}, 16'(ref_mul(ca[k], cb[k])));
      check("corner_hi4", {15'd0, hi_a}, {15'd0, ref_hi(ca[k], cb[k], 4)});
    end
    x1_a = 4'hF; x2_a = 4'hF; #1;
    check("ff_y4", {8'h00, y_a}, 16'h00E1);

    // 8-bit corner values
    for (int k = 0; k < 2; k++) begin
      x1_b = da[k]; x2_b = db[k];
      #1;
      check("corner_y8", y_b, 16'(ref_mul(da[k], db[k])));
      check("corner_hi8", {15'd0, hi_b}, {15'd0, ref_hi(da[k], db[k], 8)});
    end

    // Registered latency: 7*9 then A*B on consecutive cycles
    @(posedge clk); #1;
    x1_a = 4'h7; x2_a = 4'h9;
    @(posedge clk); #1;
    check("lat_first", {8'h00, yreg_a}, 16'(ref_mul(7, 9)));
    x1_a = 4'hA; x2_a = 4'hB;
    #1;
    check("lat_noedge", {8'h00, yreg_a}, 16'h003F);
    @(posedge clk); #1;
    check("lat_second", {8'h00, yreg_a}, 16'(ref_mul(10, 11)));

    // Asynchronous reset between edges
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_yreg", {8'h00, yreg_a}, 16'h0000);
    check("arst_y", {8'h00, y_a}, 16'h006E);
    check("arst_hi", {15'd0, hi_a}, 16'h0001);
    @(posedge clk); #1;
    check("arst_hold", {8'h00, yreg_a}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_rel", {8'h00, yreg_a}, 16'h0000);
    @(posedge clk); #1;
    check("arst_reload", {8'h00, yreg_a}, 16'h006E);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
